// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-sharing controller.
//   state_t         : controller FSM states
//   MUL_W / PROD_W  : operand and product widths of the shared multiplier
//   DEFAULT_MAX_LAT : default completion budget in BUSY cycles
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MUL_W           = 32;
  localparam int PROD_W          = 64;
  localparam int DEFAULT_MAX_LAT = 33;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Requester-side bus of the multiplier-sharing controller.
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_mlier/req_mcand : packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_id/rsp_prodt/rsp_err : one-cycle response pulse
// Modports: master = requester side, slave = controller side.
interface mult_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]                   req_valid;
  logic [NREQ-1:0]                   req_ready;
  logic [NREQ*mult_pkg::MUL_W-1:0]   req_mlier;
  logic [NREQ*mult_pkg::MUL_W-1:0]   req_mcand;
  logic                              rsp_valid;
  logic [IDW-1:0]                    rsp_id;
  logic [mult_pkg::PROD_W-1:0]       rsp_prodt;
  logic                              rsp_err;

  modport master (
    output req_valid, req_mlier, req_mcand,
    input  req_ready, rsp_valid, rsp_id, rsp_prodt, rsp_err
  );

  modport slave (
    input  req_valid, req_mlier, req_mcand,
    output req_ready, rsp_valid, rsp_id, rsp_prodt, rsp_err
  );
endinterface

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority index (owned by the caller)
//   gnt    : one-hot grant, all zero when no request
//   gnt_id : encoded index of the granted requester
// Search order is ptr, ptr+1, ... wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic hit;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hit    = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && req[idx]) begin
        hit    = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
    if (hit) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential 32x32 signed multiplier among NREQ requesters.
//   clock, reset          : single clock, asynchronous active-high reset
//   bus (slave)           : requester handshakes in, product responses out
//   busy                  : controller not in IDLE
//   mul_start             : registered start level to the multiplier
//   mul_mlier, mul_mcand  : operands latched on grant
//   mul_prodt, mul_valid  : multiplier product and completion pulse
// An operation runs IDLE (grant) -> BUSY (wait for mul_valid or timeout)
// -> RESP (response pulse, start low) -> IDLE.
module mult_share_ctrl
  import mult_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAX_LAT = DEFAULT_MAX_LAT,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  mult_share_ctrl_if.slave  bus,
  output logic              busy,
  output logic              mul_start,
  output logic [MUL_W-1:0]  mul_mlier,
  output logic [MUL_W-1:0]  mul_mcand,
  input  logic [PROD_W-1:0] mul_prodt,
  input  logic              mul_valid
);

  localparam int CNTW = $clog2(MAX_LAT + 1);

  state_t            state_reg, state_next;
  logic [IDW-1:0]    ptr_reg;
  logic [IDW-1:0]    owner_reg;
  logic [CNTW-1:0]   cnt_reg;
  logic              rsp_valid_reg;
  logic [IDW-1:0]    rsp_id_reg;
  logic [PROD_W-1:0] rsp_prodt_reg;
  logic              rsp_err_reg;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic [NREQ-1:0]   ready;
  logic              grant_fire;
  logic              done_ok;
  logic              done_to;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr_reg),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready      = '0;
    grant_fire = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|gnt) begin
          ready      = gnt;
          grant_fire = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // A completion in the last allowed cycle wins over the timeout.
        if (mul_valid) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if (cnt_reg == CNTW'(MAX_LAT)) begin
          done_to    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_reg       <= '0;
      owner_reg     <= '0;
      cnt_reg       <= '0;
      mul_start     <= 1'b0;
      mul_mlier     <= '0;
      mul_mcand     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_prodt_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      if (grant_fire) begin
        ptr_reg   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        owner_reg <= gnt_id;
        mul_mlier <= bus.req_mlier[gnt_id*MUL_W +: MUL_W];
        mul_mcand <= bus.req_mcand[gnt_id*MUL_W +: MUL_W];
        mul_start <= 1'b1;
        cnt_reg   <= CNTW'(1);
      end
      if (state_reg == BUSY && !done_ok && !done_to) begin
        cnt_reg <= cnt_reg + CNTW'(1);
      end
      // Dropping start here leaves it low through RESP, so the next
      // operation always presents a fresh rising edge.
      if (done_ok || done_to) begin
        mul_start     <= 1'b0;
        rsp_valid_reg <= 1'b1;
        rsp_id_reg    <= owner_reg;
        rsp_prodt_reg <= done_ok ? mul_prodt : '0;
        rsp_err_reg   <= done_to;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_prodt = rsp_prodt_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
module tb_mult_share_ctrl;
  localparam int NREQ = 4;
  localparam int MAXL = 33;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic        mul_start;
  logic [31:0] mul_mlier;
  logic [31:0] mul_mcand;
  logic [63:0] mul_prodt;
  logic        mul_valid;

  mult_share_ctrl_if #(.NREQ(NREQ)) bus ();

  mult_share_ctrl #(.NREQ(NREQ), .MAX_LAT(MAXL)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_mlier (mul_mlier),
    .mul_mcand (mul_mcand),
    .mul_prodt (mul_prodt),
    .mul_valid (mul_valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Multiplier model: completes k cycles after start rises (k=0: never).
  int   model_k = 0;
  int   mcnt = 0;
  logic inj = 1'b0;
  logic signed [63:0] ma, mb;
  always @(posedge clock) mcnt <= mul_start ? mcnt + 1 : 0;
  always_comb begin
    ma = {{32{mul_mlier[31]}}, mul_mlier};
    mb = {{32{mul_mcand[31]}}, mul_mcand};
    mul_prodt = ma * mb;
  end
  assign mul_valid = inj | ((model_k != 0) && mul_start && (mcnt == model_k - 1));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] rdy, output int gc);
    rdy = '0;
    gc  = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.req_ready != '0) begin
        rdy = bus.req_ready;
        gc  = cyc;
        break;
      end
    end
    chk("grant_seen", 64'(gc >= 0), 64'd1);
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (bus.rsp_valid === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    chk("rsp_seen", 64'(rc >= 0), 64'd1);
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b);
    bus.req_mlier[r*32 +: 32] = a;
    bus.req_mcand[r*32 +: 32] = b;
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic do_op(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                       input int k, input logic [63:0] ep, input logic ee, input int lat);
    logic [NREQ-1:0] rdy;
    int gc, rc;
    model_k = k;
    set_req(r, a, b);
    wait_grant(rdy, gc);
    chk({tag, "_ready"}, 64'(rdy), 64'(1 << r));
    chk({tag, "_start_low_at_grant"}, 64'(mul_start), 64'd0);
    @(posedge clock); #1;
    bus.req_valid[r] = 1'b0;
    wait_rsp(rc);
    chk({tag, "_latency"}, 64'(rc - gc), 64'(lat));
    chk({tag, "_id"}, 64'(bus.rsp_id), 64'(r));
    chk({tag, "_prodt"}, bus.rsp_prodt, ep);
    chk({tag, "_err"}, 64'(bus.rsp_err), 64'(ee));
    chk({tag, "_start_low_in_resp"}, 64'(mul_start), 64'd0);
  endtask

  typedef struct {
    int          r;
    logic [31:0] mlier;
    logic [31:0] mcand;
    int          k;
    logic [63:0] prodt;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [NREQ-1:0] rdy;
    int gc, rc, viol;

    vecs[0] = '{0, 32'h00000001, 32'h7fffffff, 32, 64'h0000_0000_7fff_ffff, 1'b0, 33};
    vecs[1] = '{1, 32'hffffffff, 32'h80000000, 1,  64'h0000_0000_8000_0000, 1'b0, 2};
    vecs[2] = '{2, 32'h80000000, 32'h80000000, 5,  64'h4000_0000_0000_0000, 1'b0, 6};
    vecs[3] = '{3, 32'hfffffffe, 32'h00000003, 33, 64'hffff_ffff_ffff_fffa, 1'b0, 34};
    vecs[4] = '{0, 32'h00000000, 32'h00003039, 2,  64'h0, 1'b0, 3};
    vecs[5] = '{1, 32'h7fffffff, 32'h7fffffff, 3,  64'h3fff_ffff_0000_0001, 1'b0, 4};
    vecs[6] = '{2, 32'h12345678, 32'h9abcdef0, 0,  64'h0, 1'b1, 34};

    bus.req_valid = '0;
    bus.req_mlier = '0;
    bus.req_mcand = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_start", 64'(mul_start), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_mlier", 64'(mul_mlier), 64'd0);
    chk("reset_prodt", bus.rsp_prodt, 64'd0);

    // Table-driven single-requester operations.
    @(posedge clock); #1;
    for (int i = 0; i < 7; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].mlier, vecs[i].mcand,
            vecs[i].k, vecs[i].prodt, vecs[i].err, vecs[i].lat);
      @(posedge clock); #1;
    end

    // Spurious mul_valid after the timeout: nothing may move.
    repeat (4) @(posedge clock);
    #1 inj = 1'b1;
    @(posedge clock); #1 inj = 1'b0;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) viol++;
    end
    chk("spurious_no_effect", 64'(viol), 64'd0);
    chk("spurious_prodt_held", bus.rsp_prodt, 64'd0);
    chk("spurious_err_held", 64'(bus.rsp_err), 64'd1);

    // All four requesters valid out of reset: grants 0,1,2,3.
    @(posedge clock); #1 reset = 1'b1;
    model_k = 3;
    for (int r = 0; r < NREQ; r++) set_req(r, 32'hffffffff, 32'h80000000);
    @(posedge clock); #1 reset = 1'b0;
    for (int n = 0; n < NREQ; n++) begin
      wait_grant(rdy, gc);
      chk($sformatf("rr4_grant%0d", n), 64'(rdy), 64'(1 << n));
      chk($sformatf("rr4_start_low%0d", n), 64'(mul_start), 64'd0);
      @(posedge clock); #1 bus.req_valid[n] = 1'b0;
      wait_rsp(rc);
      chk($sformatf("rr4_id%0d", n), 64'(bus.rsp_id), 64'(n));
      chk($sformatf("rr4_prodt%0d", n), bus.rsp_prodt, 64'h0000_0000_8000_0000);
    end

    // Requesters 1 and 3 held valid: grants alternate 1,3,1,3.
    model_k = 2;
    set_req(1, 32'h00000003, 32'h00000005);
    set_req(3, 32'hfffffffe, 32'h00000007);
    for (int n = 0; n < 4; n++) begin
      wait_grant(rdy, gc);
      chk($sformatf("alt_grant%0d", n), 64'(rdy), (n % 2 == 0) ? 64'b0010 : 64'b1000);
      if (n == 3) begin
        @(posedge clock); #1 bus.req_valid = '0;
      end
      wait_rsp(rc);
      chk($sformatf("alt_prodt%0d", n), bus.rsp_prodt,
          (n % 2 == 0) ? 64'd15 : 64'hffff_ffff_ffff_fff2);
    end

    // Reset 10 cycles into BUSY drops the operation and the pointer.
    @(posedge clock); #1;
    model_k = 0;
    set_req(2, 32'h00000009, 32'h0000000b);
    wait_grant(rdy, gc);
    chk("rst_pre_grant", 64'(rdy), 64'b0100);
    @(posedge clock); #1 bus.req_valid = '0;
    repeat (9) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_start_low", 64'(mul_start), 64'd0);
    chk("rst_busy_low", 64'(busy), 64'd0);
    chk("rst_mlier_clear", 64'(mul_mlier), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.rsp_valid !== 1'b0) viol++;
    end
    chk("rst_no_response", 64'(viol), 64'd0);
    @(posedge clock); #1;
    model_k = 2;
    for (int r = 0; r < NREQ; r++) set_req(r, 32'h00000002, 32'h00000004);
    wait_grant(rdy, gc);
    chk("rst_first_grant", 64'(rdy), 64'b0001);
    @(posedge clock); #1 bus.req_valid = '0;
    wait_rsp(rc);
    chk("rst_after_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_after_prodt", bus.rsp_prodt, 64'd8);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
